regfile_dump_ctrl: RTL and testbench

Debug-side controller that sits on the driving end of `register_file_if` (the `tb` modport side) and moves the full 32-entry register file in or out as a word stream. On `dump_start` it reads every register through the two read ports and emits them in index order over a valid/ready stream. On `load_start` it accepts 31 words and writes them into registers 1..31. It is used by the halt/debug path and by the system bench to snapshot or preload architectural state.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/register_file_if.sv | 15 +
 rtl/regfile_dump_ctrl.sv | 178 +++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the register-dump controller state encoding.
// REGDUMP_CHECKSUM_EN adds the CSUM state used for the trailing checksum beat.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_DUMP_LO = 3'd1,
    RD_DUMP_HI = 3'd2,
    RD_LOAD    = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
    RD_CSUM    = 3'd4,
`endif
    RD_DONE    = 3'd5
  } regdump_state_t;

endpackage

// File: rtl/register_file_if.sv
// Register file port bundle; the tb modport is the side that drives selects and writes.
interface register_file_if;
  import cpu_types_pkg::*;

  logic     WEN;
  regbits_t wsel;
  word_t    wdat;
  regbits_t rsel1;
  regbits_t rsel2;
  word_t    rdat1;
  word_t    rdat2;

  modport rf (input WEN, wsel, wdat, rsel1, rsel2, output rdat1, rdat2);
  modport tb (output WEN, wsel, wdat, rsel1, rsel2, input rdat1, rdat2);
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Streams the 32-entry register file out (dump) or in (load, r1..r31).
// Define REGDUMP_CHECKSUM_EN to append a wrapping-sum beat to every dump.
module regfile_dump_ctrl
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     dump_start,
  input  logic     load_start,
  output logic     busy,
  output logic     done,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    out_data,
  output regbits_t out_idx,
  output logic     out_last,
  input  logic     in_valid,
  output logic     in_ready,
  input  word_t    in_data,
  output logic     WEN,
  output regbits_t wsel,
  output word_t    wdat,
  output regbits_t rsel1,
  output regbits_t rsel2,
  input  word_t    rdat1,
  input  word_t    rdat2
);

  localparam logic [3:0] K_LAST   = 4'(REG_COUNT / 2 - 1);
  localparam regbits_t   PTR_LAST = 5'(REG_COUNT - 1);

  register_file_if rfif ();

  regdump_state_t state_q, state_d;
  logic [3:0]     k_q, k_d;
  regbits_t       ptr_q, ptr_d;
  word_t          hold_q, hold_d;
`ifdef REGDUMP_CHECKSUM_EN
  word_t          sum_q, sum_d;
`endif

  assign WEN          = rfif.WEN;
  assign wsel         = rfif.wsel;
  assign wdat         = rfif.wdat;
  assign rsel1        = rfif.rsel1;
  assign rsel2        = rfif.rsel2;
  assign rfif.rdat1   = rdat1;
  assign rfif.rdat2   = rdat2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RD_IDLE;
      k_q     <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
`ifdef REGDUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_idx    = '0;
    out_last   = 1'b0;
    in_ready   = 1'b0;
    rfif.WEN   = 1'b0;
    rfif.wsel  = '0;
    rfif.wdat  = '0;
    rfif.rsel1 = '0;
    rfif.rsel2 = '0;

    case (state_q)
      RD_IDLE: begin
        if (dump_start) begin
          state_d = RD_DUMP_LO;
          k_d     = '0;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end else if (load_start) begin
          state_d = RD_LOAD;
          ptr_d   = 5'd1;
        end
      end

      // Both read ports fetch a register pair; the odd one waits in hold_q.
      RD_DUMP_LO: begin
        busy       = 1'b1;
        rfif.rsel1 = {k_q, 1'b0};
        rfif.rsel2 = {k_q, 1'b1};
        out_valid  = 1'b1;
        out_data   = rfif.rdat1;
        out_idx    = {k_q, 1'b0};
        if (out_ready) begin
          hold_d  = rfif.rdat2;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = sum_q + rfif.rdat1;
`endif
          state_d = RD_DUMP_HI;
        end
      end

      RD_DUMP_HI: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = hold_q;
        out_idx   = {k_q, 1'b1};
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = (k_q == K_LAST);
`endif
        if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          sum_d = sum_q + hold_q;
`endif
          if (k_q == K_LAST) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = RD_CSUM;
`else
            state_d = RD_DONE;
`endif
          end else begin
            k_d     = k_q + 4'd1;
            state_d = RD_DUMP_LO;
          end
        end
      end

`ifdef REGDUMP_CHECKSUM_EN
      RD_CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sum_q;
        out_last  = 1'b1;
        if (out_ready) state_d = RD_DONE;
      end
`endif

      RD_LOAD: begin
        busy      = 1'b1;
        in_ready  = 1'b1;
        rfif.WEN  = in_valid;
        rfif.wsel = ptr_q;
        rfif.wdat = in_data;
        if (in_valid) begin
          ptr_d = ptr_q + 5'd1;
          if (ptr_q == PTR_LAST) state_d = RD_DONE;
        end
      end

      RD_DONE: begin
        done    = 1'b1;
        state_d = RD_IDLE;
      end

      default: state_d = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file model.
module tb_regfile_dump_ctrl;
  import cpu_types_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic     CLK = 1'b0;
  logic     RST;
  logic     dump_start, load_start, busy, done;
  logic     out_valid, out_ready, out_last;
  word_t    out_data;
  regbits_t out_idx;
  logic     in_valid, in_ready;
  word_t    in_data;
  logic     WEN;
  regbits_t wsel, rsel1, rsel2;
  word_t    wdat, rdat1, rdat2;

  word_t regs [32];
  word_t expv [32];
  int    wen_cnt = 0;
  int    nvec = 0;
  int    nerr = 0;

  typedef struct {
    logic     ready;
    regbits_t idx;
    word_t    data;
  } stall_vec_t;
  stall_vec_t tbl [10];

  always #5 CLK = ~CLK;

  assign rdat1 = regs[rsel1];
  assign rdat2 = regs[rsel2];

  always @(posedge CLK) begin
    if (WEN) begin
      wen_cnt <= wen_cnt + 1;
      if (wsel != 5'd0) regs[wsel] <= wdat;
    end
  end

  regfile_dump_ctrl dut (
    .CLK(CLK), .RST(RST), .dump_start(dump_start), .load_start(load_start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel1(rsel1), .rsel2(rsel2),
    .rdat1(rdat1), .rdat2(rdat2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {26'd0, busy, done, out_valid, out_last, in_ready, WEN}, 32'd0);
    chk({name, "_dat"}, out_data | wdat, 32'd0);
    chk({name, "_sel"}, {17'd0, out_idx, wsel, rsel1}, 32'd0);
    chk({name, "_rs2"}, {27'd0, rsel2}, 32'd0);
  endtask

  function automatic word_t exp_beat(input int b);
    word_t s = '0;
    if (b < 32) return expv[b];
    for (int i = 0; i < 32; i++) s += expv[i];
    return s;
  endfunction

  task automatic run_dump(input bit both, input bit poke_load);
    int beats = 0, cyc = 0, w0, done_cyc = -1;
    bit got_done = 0;
    out_ready  = 1'b1;
    dump_start = 1'b1;
    load_start = both;
    step();
    dump_start = 1'b0;
    load_start = 1'b0;
    w0 = wen_cnt;
    chk("dump_first_valid", {31'd0, out_valid}, 32'd1);
    while (!got_done && cyc < 200) begin
      load_start = (poke_load && cyc == 5);
      if (out_valid) begin
        chk("dump_idx",  {27'd0, out_idx}, (beats < 32) ? beats : 0);
        chk("dump_data", out_data, exp_beat(beats));
        chk("dump_last", {31'd0, out_last}, {31'd0, (beats == NB - 1)});
        beats++;
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end
    load_start = 1'b0;
    chk("dump_done_seen", {31'd0, got_done}, 32'd1);
    chk("dump_beats", beats, NB);
    chk("dump_done_cyc", done_cyc, NB);
    chk("dump_no_wen", wen_cnt - w0, 0);
    chk("dump_idle", {30'd0, busy, done}, 32'd0);
    step();
    chk("dump_still_idle", {29'd0, busy, in_ready, out_valid}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd0, 32'h0000_0000};
    tbl[1] = '{1'b0, 5'd1, 32'h1000_0001};
    tbl[2] = '{1'b0, 5'd1, 32'h1000_0001};
    tbl[3] = '{1'b1, 5'd1, 32'h1000_0001};
    tbl[4] = '{1'b1, 5'd2, 32'h1000_0002};
    tbl[5] = '{1'b0, 5'd3, 32'h1000_0003};
    tbl[6] = '{1'b0, 5'd3, 32'h1000_0003};
    tbl[7] = '{1'b1, 5'd3, 32'h1000_0003};
    tbl[8] = '{1'b1, 5'd4, 32'h1000_0004};
    tbl[9] = '{1'b0, 5'd5, 32'h1000_0005};

    RST = 1'b1; dump_start = 0; load_start = 0; out_ready = 0; in_valid = 0; in_data = '0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
      expv[i] = regs[i];
    end
    step(); step();
    chk_all_zero("reset");
    RST = 1'b0;
    step();
    chk_all_zero("idle");

    // Full dump, ready held high
    run_dump(1'b0, 1'b0);

    // Stalled dump from the vector table, then drain
    begin
      int nxt = 5, cyc = 0;
      bit got_done = 0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      foreach (tbl[i]) begin
        out_ready = tbl[i].ready;
        #1;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_idx", {27'd0, out_idx}, {27'd0, tbl[i].idx});
        chk("stall_data", out_data, tbl[i].data);
        step();
      end
      out_ready = 1'b1;
      while (!got_done && cyc < 200) begin
        if (out_valid) begin
          chk("drain_idx", {27'd0, out_idx}, (nxt < 32) ? nxt : 0);
          chk("drain_data", out_data, exp_beat(nxt));
          nxt++;
        end
        if (done) got_done = 1;
        step();
        cyc++;
      end
      chk("drain_done_seen", {31'd0, got_done}, 32'd1);
      chk("drain_beats", nxt, NB);
    end

    // Load with in_valid gaps
    begin
      int nxt = 1, cyc = 0, w0;
      bit got_done = 0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      w0 = wen_cnt;
      while (!got_done && cyc < 300) begin
        in_valid = (cyc % 3 != 2);
        in_data  = 32'hA5A5_0000 | 32'(nxt);
        #1;
        if (done) got_done = 1;
        else begin
          chk("load_ready", {31'd0, in_ready}, 32'd1);
          chk("load_wen", {31'd0, WEN}, {31'd0, in_valid});
          if (WEN) begin
            chk("load_wsel", {27'd0, wsel}, nxt);
            chk("load_wdat", wdat, 32'hA5A5_0000 | 32'(nxt));
            nxt++;
          end
        end
        step();
        cyc++;
      end
      in_valid = 1'b0;
      chk("load_done_seen", {31'd0, got_done}, 32'd1);
      chk("load_wen_count", wen_cnt - w0, 31);
      chk("load_idle", {30'd0, busy, in_ready}, 32'd0);
    end

    for (int i = 1; i < 32; i++) expv[i] = 32'hA5A5_0000 + 32'(i);
    // Dump and load requested together, plus a load request while busy
    run_dump(1'b1, 1'b1);

    // Reset during the 10th load write
    begin
      int cyc = 0, w0;
      bit hit = 0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      in_valid = 1'b1;
      while (!hit && cyc < 100) begin
        in_data = 32'h5A5A_0000 | 32'(wsel);
        #1;
        if (WEN && wsel == 5'd10) hit = 1;
        else begin
          step();
          cyc++;
        end
      end
      chk("rst_hit_10th", {31'd0, hit}, 32'd1);
      RST = 1'b1;
      w0 = wen_cnt;
      step();
      chk_all_zero("rst_mid");
      step();
      RST = 1'b0;
      step(); step();
      in_valid = 1'b0;
      chk("rst_no_wen", wen_cnt - w0, 0);
      chk("rst_r9_written", regs[9], 32'h5A5A_0009);
      chk("rst_r10_kept", regs[10], 32'hA5A5_000A);
      chk_all_zero("rst_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
